// File: rtl/esitleme_lut_birimi_pkg.sv
// Shared constants, FSM state type and arithmetic helper for the
// histogram-equalisation LUT builder.
//
//   PIXEL_SAYISI : pixels per frame; the CDF of a healthy frame ends here
//   BOLME_BIT    : divider dividend width, must hold PIXEL_SAYISI*255 + rounding
//   PIXEL_BIT    : pixel / bin index width
//   LUT_BIT      : width of one equalisation LUT entry
//   CDF_BIT      : histogram bin and CDF accumulator width
package esitleme_lut_birimi_pkg;

  localparam int PIXEL_SAYISI = 76800;
  localparam int BOLME_BIT    = 25;
  localparam int PIXEL_BIT    = 8;
  localparam int LUT_BIT      = 8;
  localparam int CDF_BIT      = 17;
  localparam int BIN_SAYISI   = 1 << PIXEL_BIT;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  typedef enum logic [2:0] {
    ESL_BOSTA = 3'd0,
    ESL_OKU   = 3'd1,
    ESL_BEKLE = 3'd2,
    ESL_BOL   = 3'd3,
    ESL_YAZ   = 3'd4,
    ESL_BITTI = 3'd5
  } esl_durum_e;

  // x*255 as (x<<8) - x so no multiplier is inferred.
  function automatic logic [BOLME_BIT-1:0] carp255(input logic [CDF_BIT-1:0] x);
    logic [BOLME_BIT-1:0] g;
    g = BOLME_BIT'(x);
    return (g << 8) - g;
  endfunction

endpackage

// File: rtl/esitleme_lut_birimi_sirali_bolucu.sv
// Sequential restoring divider, one quotient bit per cycle.
//
//   clk_i, rstn_i : clock, asynchronous active-low reset
//   stal_i        : freezes every register while high
//   basla_i       : load pulse; samples bolunen_i / bolen_i
//   bolunen_i     : dividend (BOLUNEN_W bits)
//   bolen_i       : divisor (BOLEN_W bits), must be non-zero
//   bolum_o       : truncated quotient, valid while bitti_o is high
//   bitti_o       : one-cycle pulse BOLUNEN_W+1 cycles after basla_i
module sirali_bolucu #(
  parameter int BOLUNEN_W = 25,
  parameter int BOLEN_W   = 17
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 stal_i,
  input  logic                 basla_i,
  input  logic [BOLUNEN_W-1:0] bolunen_i,
  input  logic [BOLEN_W-1:0]   bolen_i,
  output logic [BOLUNEN_W-1:0] bolum_o,
  output logic                 bitti_o
);

  localparam int SAY_W = $clog2(BOLUNEN_W + 1);

  logic [BOLUNEN_W-1:0] bolum_q;
  logic [BOLEN_W-1:0]   kalan_q;
  logic [BOLEN_W-1:0]   bolen_q;
  logic [SAY_W-1:0]     sayac_q;
  logic                 bitti_q;

  // Partial remainder shifted left with the next dividend bit. Dividend
  // bits are consumed from the top of bolum_q while quotient bits enter
  // at the bottom, so one register serves both roles.
  logic [BOLEN_W:0]     kaydir;
  logic                 buyuk_esit;
  logic [BOLEN_W-1:0]   fark;

  always_comb begin
    kaydir     = {kalan_q, bolum_q[BOLUNEN_W-1]};
    buyuk_esit = (kaydir >= {1'b0, bolen_q});
    // Remainder stays below the divisor, so the low bits are enough.
    fark       = kaydir[BOLEN_W-1:0] - bolen_q;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      bolum_q <= '0;
      kalan_q <= '0;
      bolen_q <= '0;
      sayac_q <= '0;
      bitti_q <= 1'b0;
    end else if (!stal_i) begin
      bitti_q <= 1'b0;
      if (basla_i) begin
        bolum_q <= bolunen_i;
        kalan_q <= '0;
        bolen_q <= bolen_i;
        sayac_q <= SAY_W'(BOLUNEN_W);
      end else if (sayac_q != '0) begin
        bolum_q <= {bolum_q[BOLUNEN_W-2:0], buyuk_esit};
        kalan_q <= buyuk_esit ? fark : kaydir[BOLEN_W-1:0];
        sayac_q <= sayac_q - SAY_W'(1);
        if (sayac_q == SAY_W'(1)) bitti_q <= 1'b1;
      end
    end
  end

  assign bolum_o = bolum_q;
  assign bitti_o = bitti_q;

endmodule

// File: rtl/esitleme_lut_birimi.sv
// Equalisation LUT builder. On a rising edge of basla_i it walks the 256
// histogram bins, accumulates the CDF and writes
//   lut[k] = round((cdf[k] - cdf_min) * 255 / (PIXEL_SAYISI - cdf_min))
// into the LUT RAM read by the remap stage.
//
//   clk_i, rstn_i  : clock, asynchronous active-low reset
//   basla_i        : histogram-ready level; rising edge starts a pass
//   stal_i         : global stall, freezes all state
//   cdf_min_i      : count of the minimum pixel value
//   valid_i        : per-bin "histogram entry written" flags
//   rd_en_o        : histogram RAM read enable, active-low
//   addr_r_o       : histogram RAM read address
//   data_i         : histogram RAM data, one cycle after rd_en_o=0
//   lut_wr_o       : LUT write strobe, one cycle per bin
//   lut_addr_o     : LUT write address
//   lut_data_o     : LUT write data
//   mesgul_o       : pass in progress
//   hazir_o        : LUT complete, held until the next pass
//   hata_o         : final CDF != PIXEL_SAYISI, held until the next pass
module esitleme_lut_birimi
  import esitleme_lut_birimi_pkg::*;
#(
  parameter int PIXEL_SAYISI = esitleme_lut_birimi_pkg::PIXEL_SAYISI,
  parameter int BOLME_BIT    = esitleme_lut_birimi_pkg::BOLME_BIT
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  basla_i,
  input  logic                  stal_i,
  input  logic [CDF_BIT-1:0]    cdf_min_i,
  input  logic [BIN_SAYISI-1:0] valid_i,
  output logic                  rd_en_o,
  output logic [PIXEL_BIT-1:0]  addr_r_o,
  input  logic [CDF_BIT-1:0]    data_i,
  output logic                  lut_wr_o,
  output logic [PIXEL_BIT-1:0]  lut_addr_o,
  output logic [LUT_BIT-1:0]    lut_data_o,
  output logic                  mesgul_o,
  output logic                  hazir_o,
  output logic                  hata_o
);

  esl_durum_e           durum_q;
  logic                 basla_q;
  logic                 stal_q;
  logic [CDF_BIT-1:0]   cdf_q;
  logic [CDF_BIT-1:0]   cdf_min_q;
  logic [CDF_BIT-1:0]   payda_q;
  logic [PIXEL_BIT-1:0] bin_q;
  logic [LUT_BIT-1:0]   lut_data_q;
  logic                 hazir_q;
  logic                 hata_q;

  logic                 kabul;
  logic                 veri_gecerli;
  logic                 tekrar_oku;
  logic [CDF_BIT-1:0]   cdf_yeni;
  logic                 bol_gerek;
  logic                 bol_basla;
  logic [BOLME_BIT-1:0] bolunen;
  logic [BOLME_BIT-1:0] bolum;
  logic                 bol_bitti;
  logic [LUT_BIT-1:0]   doygun;

  always_comb begin
    kabul        = basla_i && !basla_q &&
                   (durum_q == ESL_BOSTA || durum_q == ESL_BITTI);
    veri_gecerli = valid_i[bin_q];
    // The RAM output is only trusted the cycle right after a read. If the
    // first BEKLE cycle was stalled, that cycle is gone, so BEKLE issues the
    // read again and consumes the data one cycle later.
    tekrar_oku   = (durum_q == ESL_BEKLE) && stal_q && veri_gecerli;
    cdf_yeni     = cdf_q + (veri_gecerli ? data_i : '0);
    bol_gerek    = (payda_q != '0) && (cdf_yeni > cdf_min_q);
    bol_basla    = (durum_q == ESL_BEKLE) && !stal_i && !tekrar_oku && bol_gerek;
    // payda>>1 turns the divider's truncation into round-to-nearest.
    bolunen      = BOLME_BIT'(carp255(cdf_yeni - cdf_min_q)) +
                   BOLME_BIT'(payda_q >> 1);
    doygun       = (bolum > BOLME_BIT'(255)) ? '1 : bolum[LUT_BIT-1:0];
  end

  sirali_bolucu #(
    .BOLUNEN_W (BOLME_BIT),
    .BOLEN_W   (CDF_BIT)
  ) u_bolucu (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .stal_i    (stal_i),
    .basla_i   (bol_basla),
    .bolunen_i (bolunen),
    .bolen_i   (payda_q),
    .bolum_o   (bolum),
    .bitti_o   (bol_bitti)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      durum_q    <= ESL_BOSTA;
      basla_q    <= LOW;
      stal_q     <= LOW;
      cdf_q      <= '0;
      cdf_min_q  <= '0;
      payda_q    <= '0;
      bin_q      <= '0;
      lut_data_q <= '0;
      hazir_q    <= LOW;
      hata_q     <= LOW;
    end else begin
      // Stall history only; it records that a stall happened, not state.
      stal_q <= stal_i;
      if (!stal_i) begin
        basla_q <= basla_i;
        case (durum_q)
          ESL_BOSTA, ESL_BITTI: begin
            if (kabul) begin
              cdf_min_q <= cdf_min_i;
              payda_q   <= CDF_BIT'(PIXEL_SAYISI) - cdf_min_i;
              cdf_q     <= '0;
              bin_q     <= '0;
              hazir_q   <= LOW;
              hata_q    <= LOW;
              durum_q   <= ESL_OKU;
            end
          end
          ESL_OKU: durum_q <= ESL_BEKLE;
          ESL_BEKLE: begin
            if (!tekrar_oku) begin
              cdf_q <= cdf_yeni;
              if (payda_q == '0) begin
                // Flat image: identity mapping.
                lut_data_q <= LUT_BIT'(bin_q);
                durum_q    <= ESL_YAZ;
              end else if (!bol_gerek) begin
                lut_data_q <= '0;
                durum_q    <= ESL_YAZ;
              end else begin
                durum_q    <= ESL_BOL;
              end
            end
          end
          ESL_BOL: begin
            if (bol_bitti) begin
              lut_data_q <= doygun;
              durum_q    <= ESL_YAZ;
            end
          end
          ESL_YAZ: begin
            if (bin_q == '1) begin
              hazir_q <= HIGH;
              hata_q  <= (cdf_q != CDF_BIT'(PIXEL_SAYISI));
              durum_q <= ESL_BITTI;
            end else begin
              bin_q   <= bin_q + PIXEL_BIT'(1);
              durum_q <= ESL_OKU;
            end
          end
          default: durum_q <= ESL_BOSTA;
        endcase
      end
    end
  end

  // Strobes are gated by stal_i so nothing is issued in a frozen cycle.
  assign rd_en_o    = ~(((durum_q == ESL_OKU) || tekrar_oku) && veri_gecerli && !stal_i);
  assign addr_r_o   = bin_q;
  assign lut_wr_o   = (durum_q == ESL_YAZ) && !stal_i;
  assign lut_addr_o = bin_q;
  assign lut_data_o = lut_data_q;
  assign mesgul_o   = !(durum_q == ESL_BOSTA || durum_q == ESL_BITTI);
  assign hazir_o    = hazir_q;
  assign hata_o     = hata_q;

endmodule

// File: tb/tb_esitleme_lut_birimi.sv
module tb_esitleme_lut_birimi;

  logic         clk = 1'b0;
  logic         rstn;
  logic         basla;
  logic         stal = 1'b0;
  logic [16:0]  cdf_min;
  logic [255:0] valid;
  logic         rd_en;
  logic [7:0]   addr_r;
  logic [16:0]  data;
  logic         lut_wr;
  logic [7:0]   lut_addr;
  logic [7:0]   lut_data;
  logic         mesgul, hazir, hata;

  always #5 clk = ~clk;

  esitleme_lut_birimi dut (
    .clk_i(clk), .rstn_i(rstn), .basla_i(basla), .stal_i(stal),
    .cdf_min_i(cdf_min), .valid_i(valid), .rd_en_o(rd_en), .addr_r_o(addr_r),
    .data_i(data), .lut_wr_o(lut_wr), .lut_addr_o(lut_addr), .lut_data_o(lut_data),
    .mesgul_o(mesgul), .hazir_o(hazir), .hata_o(hata)
  );

  int hist[256];
  int lut_got[256];
  int lut_exp[256];
  bit exp_hata;
  int checks = 0, errors = 0;
  int cyc = 0, wr_cnt = 0, last_wr = 0, divs = 0, bad_gap = 0, viol = 0;
  bit stall_en = 1'b0;

  // Histogram RAM: data only meaningful the cycle after a read, junk otherwise.
  always @(posedge clk) data <= !rd_en ? 17'(hist[addr_r]) : 17'($urandom);

  always @(posedge clk) begin
    #2;
    stal = stall_en && ($urandom_range(0, 99) < 30);
  end

  // Write capture, strobe spacing and stall-rule watch.
  always @(negedge clk) begin
    cyc++;
    if (rstn) begin
      if (stal && (lut_wr || !rd_en)) viol++;
      if (lut_wr) begin
        lut_got[lut_addr] = lut_data;
        if (wr_cnt > 0) begin
          if (cyc - last_wr == 29) divs++;
          else if (cyc - last_wr != 3) bad_gap++;
        end
        wr_cnt++;
        last_wr = cyc;
      end
    end
  end

  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Reference: spec formula with plain integer arithmetic.
  task automatic model_calc(input int cmin, input bit [255:0] v);
    int cdf;
    int payda;
    longint q;
    cdf = 0;
    payda = (76800 - cmin) & 'h1FFFF;
    for (int k = 0; k < 256; k++) begin
      if (v[k]) cdf = (cdf + hist[k]) & 'h1FFFF;
      if (payda == 0) lut_exp[k] = k;
      else if (cdf <= cmin) lut_exp[k] = 0;
      else begin
        q = (longint'(cdf - cmin) * 255 + payda / 2) / payda;
        lut_exp[k] = (q > 255) ? 255 : int'(q);
      end
    end
    exp_hata = (cdf != 76800);
  endtask

  task automatic set_hist(input int desen);
    valid = '0;
    for (int k = 0; k < 256; k++) hist[k] = 999;
    case (desen)
      0: begin for (int k = 0; k < 256; k++) hist[k] = 300; valid = '1; cdf_min = 17'd300; end
      1: begin hist[100] = 76800; valid[100] = 1'b1; cdf_min = 17'd76800; end
      2: begin hist[10] = 38400; hist[200] = 38400; valid[10] = 1'b1; valid[200] = 1'b1;
               cdf_min = 17'd38400; end
      default: begin for (int k = 0; k < 256; k++) hist[k] = 100; valid = '1; cdf_min = 17'd100; end
    endcase
  endtask

  task automatic start_edge();
    stall_en = 1'b0;
    basla = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    wr_cnt = 0; divs = 0; bad_gap = 0; viol = 0; last_wr = 0;
    for (int k = 0; k < 256; k++) lut_got[k] = -1;
    basla = 1'b1;
  endtask

  task automatic run_pass(input string nm, input bit with_stall);
    int n;
    start_edge();
    stall_en = with_stall;
    n = 0;
    while (!mesgul && n < 200) begin @(negedge clk); n++; end
    while (!hazir && n < 40000) begin @(negedge clk); n++; end
    stall_en = 1'b0;
    chk({nm, " pass completed in budget"}, (n < 40000 && hazir) ? 1 : 0, 1);
    @(negedge clk);
  endtask

  task automatic lut_cmp(input string nm);
    int bad;
    bad = 0;
    for (int k = 0; k < 256; k++)
      if (lut_got[k] != lut_exp[k]) begin
        if (bad == 0)
          $display("FAIL %s lut[%0d]: got %0d expected %0d", nm, k, lut_got[k], lut_exp[k]);
        bad++;
      end
    chk({nm, " lut entries off"}, bad, 0);
    chk({nm, " strobes"}, wr_cnt, 256);
  endtask

  typedef struct {
    int desen;
    bit hata;
    int lut0, lut127, lut255;
    int divs;
  } vek_t;
  vek_t vek[4];

  initial begin
    vek[0] = '{desen: 0, hata: 1'b0, lut0: 0, lut127: 127, lut255: 255, divs: 255};
    vek[1] = '{desen: 1, hata: 1'b0, lut0: 0, lut127: 127, lut255: 255, divs: 0};
    vek[2] = '{desen: 2, hata: 1'b0, lut0: 0, lut127: 0,   lut255: 255, divs: 56};
    vek[3] = '{desen: 3, hata: 1'b1, lut0: 0, lut127: 42,  lut255: 85,  divs: 255};

    rstn = 1'b0; basla = 1'b0; cdf_min = '0; valid = '0;
    for (int k = 0; k < 256; k++) hist[k] = 0;
    repeat (3) @(negedge clk);
    chk("reset rd_en", rd_en, 1);
    chk("reset lut_wr", lut_wr, 0);
    chk("reset addr_r", addr_r, 0);
    chk("reset lut_addr/data", {lut_addr, lut_data}, 0);
    chk("reset mesgul/hazir/hata", {mesgul, hazir, hata}, 0);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      set_hist(vek[i].desen);
      model_calc(int'(cdf_min), valid);
      run_pass(nm, 1'b0);
      chk({nm, " hazir"}, hazir, 1);
      chk({nm, " hata"}, hata, vek[i].hata);
      chk({nm, " model hata"}, hata, exp_hata);
      chk({nm, " lut0"}, lut_got[0], vek[i].lut0);
      chk({nm, " lut127"}, lut_got[127], vek[i].lut127);
      chk({nm, " lut255"}, lut_got[255], vek[i].lut255);
      chk({nm, " divide visits"}, divs, vek[i].divs);
      chk({nm, " bin latency"}, bad_gap, 0);
      lut_cmp(nm);
    end

    // basla still high: no retrigger without a fresh edge.
    repeat (20) @(negedge clk);
    chk("held basla mesgul", mesgul, 0);
    chk("held basla hazir", hazir, 1);

    // Uniform histogram under random stalls.
    set_hist(0);
    model_calc(int'(cdf_min), valid);
    run_pass("stall", 1'b1);
    chk("stall strobe/read during stall", viol, 0);
    chk("stall hata", hata, 0);
    lut_cmp("stall");

    // Random histograms against the model.
    for (int r = 0; r < 2; r++) begin
      string nm;
      nm = $sformatf("rand%0d", r);
      for (int k = 0; k < 256; k++) begin
        hist[k] = $urandom_range(0, 700);
        valid[k] = ($urandom_range(0, 9) < 8);
      end
      cdf_min = 17'($urandom_range(0, 1500));
      model_calc(int'(cdf_min), valid);
      run_pass(nm, r[0]);
      chk({nm, " hata"}, hata, exp_hata);
      chk({nm, " stall rule"}, viol, 0);
      lut_cmp(nm);
    end

    // Asynchronous reset in the middle of bin 77.
    begin
      int n;
      int wr_at_rst;
      set_hist(0);
      start_edge();
      n = 0;
      while (!(mesgul && addr_r == 8'd77) && n < 5000) begin @(negedge clk); n++; end
      chk("reached bin 77", (n < 5000) ? 1 : 0, 1);
      #2 rstn = 1'b0;
      #1;
      chk("midreset rd_en", rd_en, 1);
      chk("midreset lut_wr", lut_wr, 0);
      chk("midreset addr_r/lut_addr", {addr_r, lut_addr}, 0);
      chk("midreset lut_data", lut_data, 0);
      chk("midreset mesgul/hazir/hata", {mesgul, hazir, hata}, 0);
      wr_at_rst = wr_cnt;
      repeat (3) @(negedge clk);
      chk("no strobe in reset", wr_cnt, wr_at_rst);
      rstn = 1'b1;
      model_calc(int'(cdf_min), valid);
      run_pass("restart", 1'b0);
      chk("restart hazir", hazir, 1);
      lut_cmp("restart");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
